// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU codes, IR opcodes, sequencer states and decode helpers
package alu_seq_pkg;
   localparam logic [4:0] ALU_NOP = 5'b00000, ALU_ADD = 5'b00001, ALU_SUB = 5'b00010, ALU_MUL = 5'b00011,
                          ALU_DIV = 5'b00100, ALU_SHR = 5'b00101, ALU_SHL = 5'b00110, ALU_SHRA = 5'b00111,
                          ALU_ROR = 5'b01000, ALU_ROL = 5'b01001, ALU_AND = 5'b01010, ALU_OR = 5'b01011,
                          ALU_NEG = 5'b01100, ALU_NOT = 5'b01111;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
                          OP_ROR = 5'b00111, OP_ROL = 5'b01000, OP_SHR = 5'b01001, OP_SHRA = 5'b01010,
                          OP_SHL = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110,
                          OP_DIV = 5'b01111, OP_MUL = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010;
   typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
   // instruction class: register, immediate, two-operand mul/div, unary, illegal
   typedef enum logic [2:0] {C_R, C_I, C_M, C_U, C_X} cls_t;
   typedef struct packed {
      logic pc_out, mar_in, read, mdr_in, mdr_out, ir_in;
      logic gra, grb, grc, rin, rout, cout, yin, zin, zlo_out, zhi_out, hi_in, lo_in;
   } strb_t;

   function automatic cls_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: return C_R;
         OP_ADDI, OP_ANDI, OP_ORI: return C_I;
         OP_DIV, OP_MUL: return C_M;
         OP_NEG, OP_NOT: return C_U;
         default: return C_X;
      endcase
   endfunction

   function automatic logic [4:0] op_to_alu(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB: return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI: return ALU_OR;
         OP_ROR: return ALU_ROR;
         OP_ROL: return ALU_ROL;
         OP_SHR: return ALU_SHR;
         OP_SHRA: return ALU_SHRA;
         OP_SHL: return ALU_SHL;
         OP_DIV: return ALU_DIV;
         OP_MUL: return ALU_MUL;
         OP_NEG: return ALU_NEG;
         OP_NOT: return ALU_NOT;
         default: return ALU_NOP;
      endcase
   endfunction

   // datapath strobes for a step; the class only matters from T3 on
   function automatic strb_t step_strobes(input state_t s, input cls_t c);
      strb_t v;
      logic rf, m, u;
      rf = c == C_R || c == C_I;
      m = c == C_M;
      u = c == C_U;
      v.pc_out = s == S_T0;
      v.mar_in = s == S_T0;
      v.read = s == S_T1;
      v.mdr_in = s == S_T1;
      v.mdr_out = s == S_T2;
      v.ir_in = s == S_T2;
      v.gra = (s == S_T3 && m) || (s == S_T5 && rf) || (s == S_T4 && u);
      v.grb = (s == S_T3 && !m) || (s == S_T4 && m);
      v.grc = s == S_T4 && c == C_R;
      v.rin = (s == S_T5 && rf) || (s == S_T4 && u);
      v.rout = s == S_T3 || (s == S_T4 && (c == C_R || m));
      v.cout = s == S_T4 && c == C_I;
      v.yin = s == S_T3 && !u;
      v.zin = (s == S_T4 && !u) || (s == S_T3 && u);
      v.zlo_out = s == S_T5 || (s == S_T4 && u);
      v.zhi_out = s == S_T6;
      v.hi_in = s == S_T6;
      v.lo_in = s == S_T5 && m;
      return v;
   endfunction
endpackage

// File: rtl/seq_step_timer.sv
// seq_step_timer: per-step dwell counter and saturating T1 memory-wait timeout
module seq_step_timer #(
   parameter int STEP_CYCLES = 1,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic i_restart,
   input  logic i_t1,
   output logic o_tc,
   output logic o_tmo
);
   localparam int SW = $clog2(STEP_CYCLES + 1);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
   logic [SW-1:0] r_step;
   logic [TW-1:0] r_tmo;
   assign o_tc = r_step == STEP_LAST;
   assign o_tmo = r_tmo == TMO_LAST;
   // step count restarts on each state change and holds at terminal count while T1 waits; timeout runs only in T1
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         r_step <= '0;
         r_tmo <= '0;
      end else begin
         r_step <= i_restart ? '0 : o_tc ? r_step : r_step + 1'b1;
         r_tmo <= (i_restart || !i_t1) ? '0 : o_tmo ? r_tmo : r_tmo + 1'b1;
      end
endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: hardwired fetch/decode/execute strobe sequencer for ALU instructions (optional SEQ_INC_PC_EN adds incPC)
module alu_instr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int STEP_CYCLES = 1,
   parameter int MEM_TIMEOUT = 16,
   parameter int IR_W = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic            mem_rdy,
   input  logic [IR_W-1:0] ir,
   output logic            PCout,
   output logic            MARin,
   output logic            read,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            incPC,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic            Cout,
   output logic            Yin,
   output logic            Zin,
   output logic            ZLowOut,
   output logic            ZHighOut,
   output logic            HIin,
   output logic            LOin,
   output logic [4:0]      alu_op,
   output logic            busy,
   output logic            done,
   output logic            err
);
   state_t r_state, w_nxt;
   cls_t r_cls, w_cls;
   strb_t r_s;
   logic [4:0] r_op, w_op, r_alu, w_ir_op;
   logic r_busy, r_done, r_err, w_done, w_err, w_tc, w_tmo, w_restart, w_unused;
   assign w_ir_op = ir[IR_W-1 -: 5];
   assign w_unused = ^ir[IR_W-6:0];
   // opcode is sampled on the edge that enters T3 (ir must be stable by the end of T2), then held
   assign w_cls = (r_state == S_T2) ? op_class(w_ir_op) : r_cls;
   assign w_op = (r_state == S_T2) ? op_to_alu(w_ir_op) : r_op;
   assign w_restart = w_nxt != r_state;
   seq_step_timer #(.STEP_CYCLES(STEP_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk(clk), .clr(clr), .i_restart(w_restart), .i_t1(r_state == S_T1), .o_tc(w_tc), .o_tmo(w_tmo)
   );
   // next step and completion/abort flags
   always_comb begin
      w_nxt = r_state;
      w_done = 1'b0;
      w_err = 1'b0;
      case (r_state)
         S_IDLE: w_nxt = start ? S_T0 : S_IDLE;
         S_T0: w_nxt = w_tc ? S_T1 : S_T0;
         S_T1: begin
            if (w_tc && mem_rdy) w_nxt = S_T2;
            else if (w_tmo) begin
               w_nxt = S_IDLE;
               w_err = 1'b1;
            end
         end
         S_T2: if (w_tc) begin
            w_nxt = (w_cls == C_X) ? S_IDLE : S_T3;
            w_err = w_cls == C_X;
         end
         S_T3: w_nxt = w_tc ? S_T4 : S_T3;
         S_T4: if (w_tc) begin
            w_nxt = (w_cls == C_U) ? S_IDLE : S_T5;
            w_done = w_cls == C_U;
         end
         S_T5: if (w_tc) begin
            w_nxt = (w_cls == C_M) ? S_T6 : S_IDLE;
            w_done = w_cls != C_M;
         end
         S_T6: if (w_tc) begin
            w_nxt = S_IDLE;
            w_done = 1'b1;
         end
         default: w_nxt = S_IDLE;
      endcase
   end
   // state plus outputs registered from the next step so strobes are glitch-free and drop on async clear
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         r_state <= S_IDLE;
         r_cls <= C_R;
         r_op <= ALU_NOP;
         r_alu <= ALU_NOP;
         r_s <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cls <= w_cls;
         r_op <= w_op;
         r_s <= step_strobes(w_nxt, w_cls);
         r_alu <= ((w_nxt == S_T4 && w_cls != C_U) || (w_nxt == S_T3 && w_cls == C_U)) ? w_op : ALU_NOP;
         r_busy <= w_nxt != S_IDLE;
         r_done <= w_done;
         r_err <= w_err;
      end
   assign {PCout, MARin, read, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout, Cout, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin} = r_s;
   assign alu_op = r_alu;
   assign busy = r_busy;
   assign done = r_done;
   assign err = r_err;
`ifdef SEQ_INC_PC_EN
   // one pulse in the final cycle of T1, i.e. the cycle the fetch is accepted
   assign incPC = (r_state == S_T1) && w_tc && mem_rdy;
`else
   assign incPC = 1'b0;
`endif
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: directed checks of the ALU instruction sequencer against a small datapath model
module tb_alu_instr_sequencer;
   localparam logic [31:0] I_ORI = 32'h71180025;
   localparam logic [31:0] I_ADD = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
   localparam logic [31:0] I_SUB = {5'b00100, 4'd8, 4'd9, 4'd10, 15'd0};
   localparam logic [31:0] I_MUL = {5'b10000, 4'd4, 4'd5, 19'd0};
   localparam logic [31:0] I_NOT = {5'b10010, 4'd6, 4'd7, 19'd0};
   localparam logic [31:0] I_ILL = {5'b11111, 27'd0};

   logic clk = 1'b0, clr, start, start3, mem_rdy;
   logic [31:0] ir;
   logic PCout, MARin, read, MDRin, MDRout, IRin, incPC, Gra, Grb, Grc, Rin, Rout, Cout, Yin, Zin;
   logic ZLowOut, ZHighOut, HIin, LOin, busy, done, err;
   logic [4:0] alu_op, alu_op3;
   wire [21:0] o1, o3;
   assign o1 = {err, done, busy, LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, Cout, Rout, Rin, Grc, Grb, Gra,
                incPC, IRin, MDRout, MDRin, read, MARin, PCout};

   always #5 clk = ~clk;

   alu_instr_sequencer dut (
      .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
      .PCout(PCout), .MARin(MARin), .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .incPC(incPC),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Cout(Cout), .Yin(Yin), .Zin(Zin),
      .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin), .alu_op(alu_op),
      .busy(busy), .done(done), .err(err)
   );

   alu_instr_sequencer #(.STEP_CYCLES(3)) dut3 (
      .clk(clk), .clr(clr), .start(start3), .mem_rdy(mem_rdy), .ir(ir),
      .PCout(o3[0]), .MARin(o3[1]), .read(o3[2]), .MDRin(o3[3]), .MDRout(o3[4]), .IRin(o3[5]), .incPC(o3[6]),
      .Gra(o3[7]), .Grb(o3[8]), .Grc(o3[9]), .Rin(o3[10]), .Rout(o3[11]), .Cout(o3[12]), .Yin(o3[13]),
      .Zin(o3[14]), .ZLowOut(o3[15]), .ZHighOut(o3[16]), .HIin(o3[17]), .LOin(o3[18]), .alu_op(alu_op3),
      .busy(o3[19]), .done(o3[20]), .err(o3[21])
   );

   // datapath model driven by the first sequencer's strobes
   logic [31:0] R [16];
   logic [31:0] Y, HI, LO, bus, pl_val;
   logic [63:0] Z;
   logic [3:0] rsel, pl_idx;
   logic pl_en;

   function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [4:0] s;
      s = b[4:0];
      case (op)
         5'b00001: r = a + b;
         5'b00010: r = a - b;
         5'b00011: return {32'h0, a} * {32'h0, b};
         5'b00100: return {a % b, a / b};
         5'b00101: r = a >> s;
         5'b00110: r = a << s;
         5'b00111: r = $signed(a) >>> s;
         5'b01000: r = (a >> s) | (a << (6'd32 - {1'b0, s}));
         5'b01001: r = (a << s) | (a >> (6'd32 - {1'b0, s}));
         5'b01010: r = a & b;
         5'b01011: r = a | b;
         5'b01100: r = -b;
         5'b01111: r = ~b;
         default: r = 32'h0;
      endcase
      return {32'h0, r};
   endfunction

   always_comb begin
      rsel = Gra ? ir[26:23] : Grb ? ir[22:19] : ir[18:15];
      bus = Rout ? R[rsel] : Cout ? {{13{ir[18]}}, ir[18:0]} : ZLowOut ? Z[31:0] : ZHighOut ? Z[63:32] : 32'h0;
   end

   always @(posedge clk) begin
      if (pl_en) R[pl_idx] <= pl_val;
      else if (Rin) R[rsel] <= bus;
      if (Yin) Y <= bus;
      if (Zin) Z <= alu(alu_op, Y, bus);
      if (HIin) HI <= bus;
      if (LOin) LO <= bus;
   end

   int total = 0, bad = 0;
   int n, busy1, c_rin, c_hi, c_lo, c_inc, c_read, c_alu, lo_at, hi_at, c_done;
   int k_pc, k_read, k_ir, k_yin, k_zin, k_rin, k_alu, k_inc;
   logic [4:0] alu_seen;
   logic alu_t4;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      pl_en = 1'b1;
      pl_idx = idx;
      pl_val = val;
      step();
      pl_en = 1'b0;
   endtask

   task automatic acc();
      if (Rin) c_rin++;
      if (HIin) begin c_hi++; hi_at = n; end
      if (LOin) begin c_lo++; lo_at = n; end
      if (incPC) c_inc++;
      if (read) c_read++;
      if (alu_op != 5'b0) begin
         c_alu++;
         alu_seen = alu_op;
         alu_t4 = Grc && Zin;
      end
   endtask

   task automatic acc3();
      if (o3[0]) k_pc++;
      if (o3[2]) k_read++;
      if (o3[5]) k_ir++;
      if (o3[13]) k_yin++;
      if (o3[14]) k_zin++;
      if (o3[10]) k_rin++;
      if (o3[6]) k_inc++;
      if (alu_op3 != 5'b0) k_alu++;
   endtask

   // one-cycle start pulse, then run until done/err or a cycle budget; n is the cycle done/err is seen
   task automatic go(input logic [31:0] instr);
      ir = instr;
      start = 1'b1;
      {c_rin, c_hi, c_lo, c_inc, c_read, c_alu, lo_at, hi_at} = '0;
      alu_seen = 5'b0;
      alu_t4 = 1'b0;
      step();
      start = 1'b0;
      n = 1;
      busy1 = int'(busy);
      acc();
      while (!done && !err && n < 40) begin
         step();
         n++;
         acc();
      end
   endtask

   initial begin
      clr = 1'b0;
      start = 1'b1;
      start3 = 1'b1;
      mem_rdy = 1'b1;
      ir = 32'h0;
      pl_en = 1'b0;
      pl_idx = 4'd0;
      pl_val = 32'h0;
      step();
      step();
      chk("rst_outputs", o1, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_outputs3", o3, 0);
      start = 1'b0;
      start3 = 1'b0;
      #2 clr = 1'b1;
      step();
      chk("idle_after_rst", o1, 0);

      preload(3, 5);
      go(I_ORI);
      chk("ori_busy", busy1, 1);
      chk("ori_cycles", n, 7);
      chk("ori_done", done, 1);
      chk("ori_err", err, 0);
      chk("ori_busy_end", busy, 0);
      chk("ori_r2", R[2], 37);
      chk("ori_rin_cycles", c_rin, 1);
`ifdef SEQ_INC_PC_EN
      chk("ori_incpc", c_inc, 1);
`else
      chk("ori_incpc", c_inc, 0);
`endif

      preload(2, 7);
      preload(3, 9);
      go(I_ADD);
      chk("add_cycles", n, 7);
      chk("add_r1", R[1], 16);
      chk("add_alu_cycles", c_alu, 1);
      chk("add_alu_op", alu_seen, 5'b00001);
      chk("add_alu_in_t4", alu_t4, 1);
      go(I_ADD);
      chk("b2b_busy", busy1, 1);
      chk("b2b_cycles", n, 7);
      chk("b2b_done", done, 1);

      preload(9, 3);
      preload(10, 5);
      go(I_SUB);
      chk("sub_r8", R[8], 32'hFFFFFFFE);

      preload(4, 32'h10000);
      preload(5, 32'h30000);
      go(I_MUL);
      chk("mul_cycles", n, 8);
      chk("mul_lo", LO, 0);
      chk("mul_hi", HI, 3);
      chk("mul_lo_at_t5", lo_at, 6);
      chk("mul_hi_at_t6", hi_at, 7);
      chk("mul_no_rin", c_rin, 0);

      preload(7, 32'h0F0F0F0F);
      go(I_NOT);
      chk("not_cycles", n, 6);
      chk("not_r6", R[6], 32'hF0F0F0F0);

      go(I_ILL);
      chk("ill_cycles", n, 4);
      chk("ill_err", err, 1);
      chk("ill_done", done, 0);
      chk("ill_busy", busy, 0);
      chk("ill_no_writes", c_rin + c_hi + c_lo, 0);

      mem_rdy = 1'b0;
      go(I_ADD);
      chk("tmo_cycles", n, 18);
      chk("tmo_err", err, 1);
      chk("tmo_done", done, 0);
      chk("tmo_read_cycles", c_read, 16);
      chk("tmo_incpc", c_inc, 0);
      mem_rdy = 1'b1;
      step();

      preload(1, 0);
      ir = I_ADD;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("mid_t4_zin", Zin, 1);
      chk("mid_t4_alu_op", alu_op, 5'b00001);
      #2 clr = 1'b0;
      #1;
      chk("clr_drop", o1, 0);
      chk("clr_drop_alu_op", alu_op, 0);
      c_done = 0;
      repeat (3) begin
         step();
         if (done || err) c_done++;
      end
      #2 clr = 1'b1;
      repeat (4) begin
         step();
         if (done || err) c_done++;
      end
      chk("clr_no_done", c_done, 0);
      chk("clr_busy", busy, 0);
      chk("clr_r1_untouched", R[1], 0);

      ir = I_ADD;
      start3 = 1'b1;
      {k_pc, k_read, k_ir, k_yin, k_zin, k_rin, k_alu, k_inc} = '0;
      step();
      start3 = 1'b0;
      n = 1;
      acc3();
      while (!o3[20] && !o3[21] && n < 60) begin
         step();
         n++;
         acc3();
      end
      chk("s3_cycles", n, 19);
      chk("s3_done", o3[20], 1);
      chk("s3_pcout_w", k_pc, 3);
      chk("s3_read_w", k_read, 3);
      chk("s3_irin_w", k_ir, 3);
      chk("s3_yin_w", k_yin, 3);
      chk("s3_zin_w", k_zin, 3);
      chk("s3_rin_w", k_rin, 3);
      chk("s3_alu_w", k_alu, 3);
`ifdef SEQ_INC_PC_EN
      chk("s3_incpc", k_inc, 1);
`else
      chk("s3_incpc", k_inc, 0);
`endif
      chk("s3_dut1_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
